// File: rtl/instr_issue_queue_if.sv
// ---------------------------------------------------------------------------
// instr_issue_queue_if
//   Handshake bundle around the instruction issue queue.
//   Write channel (host -> queue):
//     wr_valid, wr_func, wr_in1, wr_in2 : offered instruction
//     wr_ready                          : queue can take it
//   Issue channel (queue -> control FSM):
//     issue_valid, func, input1, input2 : issued instruction
//     issue_ready                       : control FSM accepts it
//     done                              : control FSM completion pulse
//   modport master : host / control-FSM side (the environment)
//   modport slave  : the issue queue itself
// ---------------------------------------------------------------------------
interface instr_issue_queue_if #(
    parameter int DATA_W = 16,
    parameter int FUNC_W = 4
);
    logic              wr_valid;
    logic              wr_ready;
    logic [FUNC_W-1:0] wr_func;
    logic [DATA_W-1:0] wr_in1;
    logic [DATA_W-1:0] wr_in2;

    logic              issue_valid;
    logic              issue_ready;
    logic [FUNC_W-1:0] func;
    logic [DATA_W-1:0] input1;
    logic [DATA_W-1:0] input2;
    logic              done;

    modport master (
        output wr_valid, wr_func, wr_in1, wr_in2, issue_ready, done,
        input  wr_ready, issue_valid, func, input1, input2
    );

    modport slave (
        input  wr_valid, wr_func, wr_in1, wr_in2, issue_ready, done,
        output wr_ready, issue_valid, func, input1, input2
    );
endinterface

// File: rtl/instr_issue_queue.sv
// ---------------------------------------------------------------------------
// instr_issue_queue
//   Buffers {func, input1, input2} instructions from a host and issues them
//   one at a time to the control FSM. An issued instruction is held stable
//   until accepted, after which the queue waits for the completion pulse
//   before issuing the next one (IDLE -> ISSUE -> WAIT -> IDLE).
//
// Ports
//   clk           : rising-edge clock
//   resetn        : asynchronous active-low reset
//   bus           : instr_issue_queue_if.slave (write + issue channels, done)
//   flush         : drop every queued, not-yet-issued entry this cycle
//   busy          : high while in ISSUE or WAIT
//   count         : entries currently held in the queue
//   issued_cnt    : completed-instruction count, wraps 255 -> 0
//   spurious_done : sticky, done seen outside WAIT
//   timeout_err   : sticky, WAIT exceeded TIMEOUT_CYCLES
//
// Configuration
//   ISSUE_TIMEOUT_EN : when defined, an 8-bit WAIT counter abandons an
//                      instruction whose done does not arrive within
//                      TIMEOUT_CYCLES cycles. Undefined: WAIT is unbounded
//                      and timeout_err is tied low.
// ---------------------------------------------------------------------------
module instr_issue_queue #(
    parameter int DATA_W         = 16,
    parameter int FUNC_W         = 4,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    instr_issue_queue_if.slave       bus,
    input  logic                     flush,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               issued_cnt,
    output logic                     spurious_done,
    output logic                     timeout_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
            TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_param_check
            $error("instr_issue_queue: DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES in 1..256");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state;

    logic [FUNC_W-1:0] mem_func [DEPTH];
    logic [DATA_W-1:0] mem_in1  [DEPTH];
    logic [DATA_W-1:0] mem_in2  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_next;

    logic              wr_ready_q;
    logic              issue_valid_q;
    logic [FUNC_W-1:0] func_q;
    logic [DATA_W-1:0] in1_q;
    logic [DATA_W-1:0] in2_q;

    logic              do_write;
    logic              do_pop;

`ifdef ISSUE_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]        wait_cnt;
`endif

    assign bus.wr_ready    = wr_ready_q;
    assign bus.issue_valid = issue_valid_q;
    assign bus.func        = func_q;
    assign bus.input1      = in1_q;
    assign bus.input2      = in2_q;

    // A write coinciding with flush is dropped; popping only looks at the
    // registered count, so an entry written this cycle cannot be popped
    // before the next one.
    assign do_write = bus.wr_valid && wr_ready_q && !flush;
    assign do_pop   = (state == S_IDLE) && (count != '0) && !flush;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({do_write, do_pop})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
    end

    // Entry storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_func[wr_ptr] <= bus.wr_func;
            mem_in1[wr_ptr]  <= bus.wr_in1;
            mem_in2[wr_ptr]  <= bus.wr_in2;
        end
    end

    // Queue pointers and occupancy. wr_ready follows the next count so it
    // stays low for a full queue even in a cycle that also pops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            wr_ready_q <= 1'b1;
        end else begin
            count      <= count_next;
            wr_ready_q <= (count_next != FULL_CNT);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
                if (do_pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Issue sequencer with registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            issue_valid_q <= 1'b0;
            func_q        <= '0;
            in1_q         <= '0;
            in2_q         <= '0;
            busy          <= 1'b0;
            issued_cnt    <= '0;
            spurious_done <= 1'b0;
`ifdef ISSUE_TIMEOUT_EN
            timeout_err   <= 1'b0;
            wait_cnt      <= '0;
`endif
        end else begin
            if (bus.done && state != S_WAIT) spurious_done <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (do_pop) begin
                        func_q        <= mem_func[rd_ptr];
                        in1_q         <= mem_in1[rd_ptr];
                        in2_q         <= mem_in2[rd_ptr];
                        issue_valid_q <= 1'b1;
                        busy          <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.issue_ready) begin
                        issue_valid_q <= 1'b0;
                        state         <= S_WAIT;
`ifdef ISSUE_TIMEOUT_EN
                        wait_cnt      <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    // done has priority over an expiring timeout.
                    if (bus.done) begin
                        issued_cnt <= issued_cnt + 8'd1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
`ifdef ISSUE_TIMEOUT_EN
                    else if (wait_cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    issue_valid_q <= 1'b0;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

`ifndef ISSUE_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule
